// File: rtl/dmmu_sram_sp_if.sv
// ---------------------------------------------------------------------------
// dmmu_sram_sp_if
// Access and flush bus between the MMU control logic (master) and the
// TLB match/translate array (slave, dmmu_sram_sp).
//
// Signals:
//   cs_n       master->slave  chip select, active low
//   we_n       master->slave  0 = write, 1 = read
//   oe_n       master->slave  output enable, active low (1 zeroes rdata)
//   addr       master->slave  word address, AW bits
//   wdata      master->slave  write data, DW bits
//   wmask      master->slave  per-lane write enable, NL bits
//   perr_inj   master->slave  test only: invert parity of written lanes
//   flush_req  master->slave  request a clear sweep (invalidate-all)
//   ready      slave->master  accesses accepted this cycle
//   rdata      slave->master  registered read data
//   rvalid     slave->master  one-cycle pulse when rdata was updated by a read
//   par_err    slave->master  per-lane parity error, qualified by rvalid
//   flush_busy slave->master  clear sweep in progress
//   flush_done slave->master  one-cycle pulse at sweep completion
// ---------------------------------------------------------------------------
interface dmmu_sram_sp_if #(
  parameter int AW     = 6,
  parameter int DW     = 24,
  parameter int LANE_W = 8
);
  localparam int NL = DW / LANE_W;

  logic          cs_n;
  logic          we_n;
  logic          oe_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [NL-1:0] wmask;
  logic          perr_inj;
  logic          flush_req;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic [NL-1:0] par_err;
  logic          flush_busy;
  logic          flush_done;

  modport master (
    output cs_n, we_n, oe_n, addr, wdata, wmask, perr_inj, flush_req,
    input  ready, rdata, rvalid, par_err, flush_busy, flush_done
  );

  modport slave (
    input  cs_n, we_n, oe_n, addr, wdata, wmask, perr_inj, flush_req,
    output ready, rdata, rvalid, par_err, flush_busy, flush_done
  );
endinterface

// File: rtl/dmmu_sram_sp.sv
// ---------------------------------------------------------------------------
// dmmu_sram_sp
// Single-port synchronous SRAM model for the DMMU/IMMU TLB match and
// translate arrays. 2**AW words of DW bits, split into NL = DW/LANE_W lanes,
// each lane with its own write enable and even-parity bit. A hardware clear
// sweep writes INIT_VAL (with correct parity) to every word after reset and
// on flush_req, which gives the TLB its invalidate-all.
//
// Ports:
//   clk    core clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    dmmu_sram_sp_if.slave (access, flush and status signals)
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_SWEEP | clear sweep: one word per cycle, accesses ignored (ready=0)
//   ST_IDLE  | normal operation, reads and writes accepted (ready=1)
// ---------------------------------------------------------------------------
module dmmu_sram_sp #(
  parameter int              AW       = 6,
  parameter int              DW       = 24,
  parameter int              LANE_W   = 8,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmmu_sram_sp_if.slave  bus
);

  localparam int            NL       = DW / LANE_W;
  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Storage: data and per-lane parity kept side by side, never reset.
  logic [DW-1:0] mem_data [DEPTH];
  logic [NL-1:0] mem_par  [DEPTH];

  state_t        state_q,   state_d;
  logic [AW-1:0] ptr_q,     ptr_d;
  logic          ready_q,   ready_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          rvalid_q,  rvalid_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [NL-1:0] par_err_q, par_err_d;

  logic          acc;
  logic [DW-1:0] rd_word;
  logic [NL-1:0] rd_par;
  logic [NL-1:0] rd_perr;
  logic [NL-1:0] wdata_par;
  logic [NL-1:0] init_par;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NL-1:0] wr_lane;
  logic [DW-1:0] wr_data;
  logic [NL-1:0] wr_par;

  assign acc     = ready_q & ~bus.cs_n;
  assign rd_word = mem_data[bus.addr];
  assign rd_par  = mem_par[bus.addr];

  // Lane parity: even parity, so data XOR stored bit is 0 for a clean lane.
  always_comb begin
    rd_perr   = '0;
    wdata_par = '0;
    init_par  = '0;
    for (int i = 0; i < NL; i++) begin
      rd_perr[i]   = (^rd_word[i*LANE_W +: LANE_W]) ^ rd_par[i];
      wdata_par[i] = ^bus.wdata[i*LANE_W +: LANE_W];
      init_par[i]  = ^INIT_VAL[i*LANE_W +: LANE_W];
    end
  end

  // Single array write port, shared between the sweep and accepted writes.
  // ready_q is 0 throughout the sweep, so the two never compete.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.addr;
    wr_lane = bus.wmask;
    wr_data = bus.wdata;
    wr_par  = wdata_par ^ {NL{bus.perr_inj}};
    if (state_q == ST_SWEEP) begin
      wr_en   = 1'b1;
      wr_addr = ptr_q;
      wr_lane = '1;
      wr_data = INIT_VAL;
      wr_par  = init_par;
    end else if (acc && !bus.we_n) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NL; i++) begin
        if (wr_lane[i]) begin
          mem_data[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
          mem_par[wr_addr][i]                   <= wr_par[i];
        end
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rvalid_d  = 1'b0;
    par_err_d = '0;
    rdata_d   = rdata_q;

    case (state_q)
      ST_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        // Last word written this cycle: outputs flip for the first IDLE cycle.
        // flush_req is deliberately not looked at here.
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        ptr_d   = '0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
      end
    endcase

    // An access in the flush_req cycle is still accepted since ready_q=1.
    if (acc && bus.we_n) begin
      rvalid_d  = 1'b1;
      rdata_d   = bus.oe_n ? '0 : rd_word;
      par_err_d = rd_perr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SWEEP;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      par_err_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      par_err_q <= par_err_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.flush_busy = busy_q;
  assign bus.flush_done = done_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.par_err    = par_err_q;

endmodule

// File: tb/tb_dmmu_sram_sp.sv
module tb_dmmu_sram_sp;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  int done_cnt;
  int bad;

  dmmu_sram_sp_if #(.AW(6), .DW(24), .LANE_W(8)) bus ();

  dmmu_sram_sp #(.AW(6), .DW(24), .LANE_W(8), .INIT_VAL(24'h000000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cs_n      = 1'b1;
    bus.we_n      = 1'b1;
    bus.oe_n      = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.wmask     = '0;
    bus.perr_inj  = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [23:0] d, input logic [2:0] m, input logic inj);
    bus.cs_n     = 1'b0;
    bus.we_n     = 1'b0;
    bus.oe_n     = 1'b0;
    bus.addr     = a;
    bus.wdata    = d;
    bus.wmask    = m;
    bus.perr_inj = inj;
  endtask

  task automatic rd(input logic [5:0] a, input logic oe);
    bus.cs_n     = 1'b0;
    bus.we_n     = 1'b1;
    bus.oe_n     = oe;
    bus.addr     = a;
    bus.perr_inj = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",      32'(bus.ready),      32'h0);
    chk("rst_rdata",      32'(bus.rdata),      32'h0);
    chk("rst_rvalid",     32'(bus.rvalid),     32'h0);
    chk("rst_par_err",    32'(bus.par_err),    32'h0);
    chk("rst_flush_done", 32'(bus.flush_done), 32'h0);
    chk("rst_flush_busy", 32'(bus.flush_busy), 32'h1);
    rst_n = 1'b1;

    // Power-up sweep
    n = 0; done_cnt = 0; bad = 0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      n++;
      if (bus.flush_done) done_cnt++;
      if (bus.flush_busy && bus.ready) bad++;
      if (!bus.flush_busy) break;
    end
    chk("sweep0_len",        32'(n),              32'd64);
    chk("sweep0_done_pulse", 32'(bus.flush_done), 32'h1);
    chk("sweep0_ready",      32'(bus.ready),      32'h1);
    chk("sweep0_ready_busy", 32'(bad),            32'h0);
    cyc();
    chk("sweep0_done_clear", 32'(bus.flush_done), 32'h0);
    chk("sweep0_done_once",  32'(done_cnt),       32'd1);

    // Back-to-back reads of the whole cleared array
    for (int i = 0; i < 64; i++) begin
      rd(6'(i), 1'b0);
      cyc();
      chk("init_rd", 32'({bus.rvalid, bus.par_err, bus.rdata}), 32'({1'b1, 3'b000, 24'h000000}));
    end
    idle();
    cyc();
    chk("idle_rvalid",  32'(bus.rvalid),  32'h0);
    chk("idle_par_err", 32'(bus.par_err), 32'h0);

    // Full write then read-after-write
    wr(6'd5, 24'hA1B2C3, 3'b111, 1'b0);
    cyc();
    chk("wr_no_rvalid", 32'(bus.rvalid), 32'h0);
    rd(6'd5, 1'b0);
    cyc();
    chk("raw_rvalid", 32'(bus.rvalid), 32'h1);
    chk("raw_rdata",  32'(bus.rdata),  32'hA1B2C3);

    // Partial lane write
    wr(6'd5, 24'hFFFFFF, 3'b010, 1'b0);
    cyc();
    rd(6'd5, 1'b0);
    cyc();
    chk("mask_rdata",   32'(bus.rdata),   32'hA1FFC3);
    chk("mask_par_err", 32'(bus.par_err), 32'h0);
    idle();
    cyc();
    chk("hold_rdata",   32'(bus.rdata),   32'hA1FFC3);
    chk("hold_rvalid",  32'(bus.rvalid),  32'h0);
    rd(6'd5, 1'b1);
    cyc();
    chk("oe_rdata",  32'(bus.rdata),  32'h0);
    chk("oe_rvalid", 32'(bus.rvalid), 32'h1);

    // Parity injection on lane 2
    wr(6'd9, 24'h123456, 3'b100, 1'b1);
    cyc();
    rd(6'd9, 1'b0);
    cyc();
    chk("perr_rdata",   32'(bus.rdata),   32'h120000);
    chk("perr_par_err", 32'(bus.par_err), 32'h4);
    rd(6'd9, 1'b1);
    cyc();
    chk("perr_oe_rdata",   32'(bus.rdata),   32'h0);
    chk("perr_oe_par_err", 32'(bus.par_err), 32'h4);
    idle();
    cyc();
    chk("perr_clear", 32'(bus.par_err), 32'h0);

    // wmask=0 is a no-op
    wr(6'd5, 24'h000000, 3'b000, 1'b0);
    cyc();
    rd(6'd5, 1'b0);
    cyc();
    chk("nomask_rdata", 32'(bus.rdata), 32'hA1FFC3);

    // Flush: access in the request cycle is accepted
    wr(6'd7, 24'h00BEEF, 3'b111, 1'b0);
    cyc();
    rd(6'd5, 1'b0);
    bus.flush_req = 1'b1;
    cyc();
    chk("flush_acc_rvalid", 32'(bus.rvalid),     32'h1);
    chk("flush_acc_rdata",  32'(bus.rdata),      32'hA1FFC3);
    chk("flush_ready",      32'(bus.ready),      32'h0);
    chk("flush_busy",       32'(bus.flush_busy), 32'h1);
    n = 0; done_cnt = 0; bad = 0;
    for (int k = 0; k < 200; k++) begin
      bus.flush_req = (n == 20);
      if (n == 40) wr(6'd3, 24'h5A5A5A, 3'b111, 1'b0);
      else         rd(6'd7, 1'b0);
      cyc();
      n++;
      if (bus.rvalid) bad++;
      if (bus.flush_done) done_cnt++;
      if (!bus.flush_busy) break;
    end
    chk("sweep1_len",       32'(n),         32'd64);
    chk("sweep1_no_rvalid", 32'(bad),       32'h0);
    chk("sweep1_done",      32'(done_cnt),  32'd1);
    chk("sweep1_ready",     32'(bus.ready), 32'h1);
    chk("sweep1_rdata",     32'(bus.rdata), 32'hA1FFC3);
    idle();
    rd(6'd7, 1'b0);
    cyc();
    chk("flushed_a7", 32'(bus.rdata), 32'h0);
    rd(6'd3, 1'b0);
    cyc();
    chk("flushed_a3", 32'(bus.rdata), 32'h0);
    rd(6'd5, 1'b0);
    cyc();
    chk("flushed_a5", 32'(bus.rdata), 32'h0);
    rd(6'd9, 1'b0);
    cyc();
    chk("flushed_a9_perr", 32'({bus.rvalid, bus.par_err, bus.rdata}), 32'({1'b1, 3'b000, 24'h000000}));

    // Reset in the middle of a sweep restarts it
    wr(6'd5, 24'h0F0F0F, 3'b111, 1'b0);
    cyc();
    rd(6'd5, 1'b0);
    cyc();
    chk("pre_rst_rdata", 32'(bus.rdata), 32'h0F0F0F);
    idle();
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    repeat (29) cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata",  32'(bus.rdata),      32'h0);
    chk("midrst_ready",  32'(bus.ready),      32'h0);
    chk("midrst_busy",   32'(bus.flush_busy), 32'h1);
    chk("midrst_rvalid", 32'(bus.rvalid),     32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0; bad = 0;
    for (int k = 0; k < 200; k++) begin
      rd(6'd5, 1'b0);
      cyc();
      n++;
      if (bus.flush_busy && (bus.ready || bus.rdata != 24'h0 || bus.rvalid)) bad++;
      if (!bus.flush_busy) break;
    end
    chk("sweep2_len",   32'(n),         32'd64);
    chk("sweep2_quiet", 32'(bad),       32'h0);
    chk("sweep2_ready", 32'(bus.ready), 32'h1);
    chk("sweep2_rdata", 32'(bus.rdata), 32'h0);
    rd(6'd5, 1'b0);
    cyc();
    chk("sweep2_rd", 32'({bus.rvalid, bus.rdata}), 32'({1'b1, 24'h000000}));
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmmu_sram_sp.md
Name: dmmu_sram_sp

Overview:
- Parametrised single-port synchronous SRAM model for DMMU/IMMU TLB match and translate arrays. Generalises the fixed 64x24 array.
- Adds configurable depth and width, per-lane write masks, and per-lane parity with error reporting.
- Adds a hardware clear sweep that writes INIT_VAL to every word. The sweep runs automatically after reset and on an explicit flush request, giving TLB invalidate-all.
- Sits between the MMU control logic and the tag/data storage, on the core clock.

Parameters:
AW, 6, address width; depth = 2**AW words
DW, 24, data word width in bits; must be a multiple of LANE_W
LANE_W, 8, write-mask/parity lane width; NL = DW/LANE_W lanes
INIT_VAL, 0, DW-bit value written to every word by the clear sweep

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cs_n  in  1  chip select, active low
we_n  in  1  0 = write, 1 = read (when selected)
oe_n  in  1  output enable, active low; 1 forces rdata to all-zero
addr  in  AW  word address
wdata  in  DW  write data
wmask  in  NL  per-lane write enable; 1 = lane written
perr_inj  in  1  test only: inverts stored parity of every lane written this cycle
flush_req  in  1  request clear sweep (level sampled)
ready  out  1  1 = accesses accepted this cycle
rdata  out  DW  read data, registered
rvalid  out  1  one-cycle pulse: rdata updated by a read
par_err  out  NL  per-lane parity error, qualified by rvalid
flush_busy  out  1  clear sweep in progress
flush_done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset values: ready=0, rdata=0, rvalid=0, par_err=0, flush_done=0, flush_busy=1.
  - Sweep pointer = 0 and FSM = SWEEP; reset asserted mid-sweep restarts the sweep from 0.
  - The array itself is not reset; the sweep defines its contents.
- FSM states: SWEEP, IDLE.
- SWEEP:
  - Each cycle writes INIT_VAL, with correct even parity per lane, to memory[ptr]; ptr increments.
  - On the cycle ptr = 2**AW-1 is written, FSM -> IDLE and ptr wraps to 0.
  - flush_done pulses and ready=1 in the first IDLE cycle; flush_busy=0 from that cycle.
  - Sweep length is exactly 2**AW cycles.
- IDLE: flush_req=1 sampled -> SWEEP next cycle. An access presented in that same cycle is still accepted.
- flush_req during SWEEP: ignored; no restart or extension.
- Accesses while ready=0: ignored. No write, rvalid stays 0, array and rdata untouched.
- Accepted access: ready=1 and cs_n=0.
- Read (we_n=1):
  - rdata <= memory[addr] on the edge, or 0 if oe_n=1 at that edge.
  - rvalid=1 for the following cycle.
  - par_err[i] = XOR of stored lane i data and its parity bit, valid with rvalid; it is computed regardless of oe_n.
  - rdata holds its last value until the next accepted read. par_err clears to 0 when rvalid=0.
- Write (we_n=0):
  - Lanes with wmask[i]=1 take wdata lane i and parity = ^lane (inverted if perr_inj=1).
  - Unmasked lanes and their parity bits are unchanged.
  - No rvalid; rdata unchanged. wmask=0 is a legal no-op.
- Read latency 1 cycle; fully pipelined, back-to-back reads every cycle.
- Read after write to the same address in the next cycle returns the new data.
- Out-of-range address is impossible (full 2**AW decode).

Test Plan:
- Reset, then hold rst_n=1 with cs_n=1 -> flush_busy=1 for 64 cycles, flush_done pulses once, ready=1. Read addr 0..63 -> rdata=0x000000, par_err=0 on all.
- Write addr 5 wdata 0xA1B2C3 wmask 3'b111, read addr 5 next cycle -> rvalid one cycle later, rdata=0xA1B2C3.
- Write addr 5 wdata 0xFFFFFF wmask 3'b010 -> read gives 0xA1FFC3. Then read with oe_n=1 -> rdata=0x000000, rvalid=1.
- Write addr 9 0x123456 with perr_inj=1, wmask 3'b100, then read addr 9 -> rdata=0x120000, par_err=3'b100.
- Write addr 7 0x00BEEF; flush_req=1 for one cycle; read issued during sweep -> ignored (rvalid=0). After flush_done, read addr 7 -> 0x000000. A second flush_req mid-sweep keeps the sweep at 64 cycles.
- Assert rst_n=0 at sweep cycle 30, release -> new sweep of exactly 64 cycles, ready=0 throughout, rdata=0.
